// File: rtl/timer_pkg.sv
// Shared definitions for the timer scheduler: timer register map, CTRL bit layout,
// scheduler FSM states and the timer bus write beat.
package timer_pkg;

  localparam logic [3:0] REG_CTRL   = 4'h0;
  localparam logic [3:0] REG_LOAD   = 4'h4;
  localparam logic [3:0] REG_VALUE  = 4'h8;
  localparam logic [3:0] REG_STATUS = 4'hC;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE     = 1;
  localparam int CTRL_PRESC_EN = 2;
  localparam int CTRL_DIV_LSB  = 8;
  localparam int CTRL_DIV_MSB  = 15;

  typedef enum logic [2:0] {
    IDLE, ARB, WR_LOAD, WR_CTRL, WAIT, CLR, DIS, DONE
  } state_e;

  typedef struct packed {
    logic        sel;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
  } timer_wr_t;

  // Mode bit is always 0: every job is a one-shot countdown.
  function automatic logic [31:0] ctrl_word(input logic en, input logic presc_en,
                                            input logic [7:0] div);
    logic [31:0] w;
    w = '0;
    w[CTRL_EN]                   = en;
    w[CTRL_MODE]                 = 1'b0;
    w[CTRL_PRESC_EN]             = presc_en;
    w[CTRL_DIV_MSB:CTRL_DIV_LSB] = div;
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request after last_i, wrapping.
// The caller owns and updates the last-grant pointer.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [N_REQ-1:0] grant_o,
  output logic             valid_o
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = IDX_W'((int'(last_i) + k) % N_REQ);
      if (!valid_o && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        valid_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_sched.sv
// Round-robin scheduler that time-shares one memory-mapped one-shot timer between
// N_REQ clients, programming it over its register port and pulsing done on expiry.
module timer_sched
  import timer_pkg::*;
#(
  parameter int         N_REQ     = 4,
  parameter bit         PRESC_EN  = 1'b0,
  parameter logic [7:0] PRESC_DIV = 8'd0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [N_REQ-1:0]      req,
  input  logic [32*N_REQ-1:0]   req_delay,
  output logic [N_REQ-1:0]      done,
  output logic                  busy,
  output logic [2:0]            grant_id,
  output logic                  t_sel,
  output logic                  t_we,
  output logic [3:0]            t_addr,
  output logic [31:0]           t_wdata,
  input  logic                  t_irq
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        grant_q, grant_d, last_q, last_d, gnt_idx;
  logic [31:0]             dly_q, dly_d;
  logic                    cancel_q, cancel_d;
  logic [N_REQ-1:0]        gnt_oh;
  logic                    arb_vld;
  logic                    req_own;
  logic [N_REQ-1:0][31:0]  dly_vec;
  timer_wr_t               wr;

  assign dly_vec = req_delay;
  assign req_own = req[grant_q];

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
    .req_i   (req),
    .last_i  (last_q),
    .grant_o (gnt_oh),
    .valid_o (arb_vld)
  );

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < N_REQ; i++)
      if (gnt_oh[i]) gnt_idx = IDX_W'(i);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      last_q   <= IDX_W'(N_REQ - 1);
      dly_q    <= '0;
      cancel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      dly_q    <= dly_d;
      cancel_q <= cancel_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    dly_d    = dly_q;
    cancel_d = cancel_q;
    case (state_q)
      IDLE: begin
        cancel_d = 1'b0;
        if (|req) state_d = ARB;
      end
      ARB: begin
        if (arb_vld) begin
          grant_d = gnt_idx;
          last_d  = gnt_idx;
          dly_d   = dly_vec[gnt_idx];
          // A zero load never times out, so skip the timer entirely.
          state_d = (dly_vec[gnt_idx] == 32'd0) ? DONE : WR_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      WR_LOAD, WR_CTRL: begin
        if (!req_own) begin
          cancel_d = 1'b1;
          state_d  = CLR;
        end else begin
          state_d = (state_q == WR_LOAD) ? WR_CTRL : WAIT;
        end
      end
      WAIT: begin
        // Expiry beats a same-cycle cancel.
        if (t_irq) state_d = CLR;
        else if (!req_own) begin
          cancel_d = 1'b1;
          state_d  = CLR;
        end
      end
      CLR:     state_d = DIS;
      DIS:     state_d = cancel_q ? IDLE : DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr = '0;
    case (state_q)
      WR_LOAD: wr = '{sel: 1'b1, we: 1'b1, addr: REG_LOAD,   wdata: dly_q};
      WR_CTRL: wr = '{sel: 1'b1, we: 1'b1, addr: REG_CTRL,
                      wdata: ctrl_word(1'b1, PRESC_EN, PRESC_DIV)};
      CLR:     wr = '{sel: 1'b1, we: 1'b1, addr: REG_STATUS, wdata: 32'h1};
      // Disabling guarantees an EN rising edge (fresh load) on the next job.
      DIS:     wr = '{sel: 1'b1, we: 1'b1, addr: REG_CTRL,   wdata: 32'h0};
      default: wr = '0;
    endcase
  end

  assign t_sel   = wr.sel;
  assign t_we    = wr.we;
  assign t_addr  = wr.addr;
  assign t_wdata = wr.wdata;

  always_comb begin
    done = '0;
    for (int i = 0; i < N_REQ; i++)
      done[i] = (state_q == DONE) && (grant_q == IDX_W'(i));
  end

  assign busy     = (state_q != IDLE);
  assign grant_id = 3'(grant_q);

endmodule

// File: tb/tb_timer_sched.sv
// Bench for timer_sched: behavioural timer, bus write log and a round-robin
// reference model driving randomized multi-client traffic.
module tb_timer_sched;
  import timer_pkg::*;

  logic              clk = 1'b0;
  logic              resetn;
  logic [3:0]        req;
  logic [3:0][31:0]  dly;
  logic [3:0]        done;
  logic              busy;
  logic [2:0]        grant_id;
  logic              t_sel, t_we;
  logic [3:0]        t_addr;
  logic [31:0]       t_wdata;
  logic              t_irq;

  int checks = 0;
  int errors = 0;

  timer_sched #(.N_REQ(4), .PRESC_EN(1'b0), .PRESC_DIV(8'd0)) dut (
    .clk(clk), .resetn(resetn), .req(req), .req_delay(dly), .done(done),
    .busy(busy), .grant_id(grant_id), .t_sel(t_sel), .t_we(t_we),
    .t_addr(t_addr), .t_wdata(t_wdata), .t_irq(t_irq)
  );

  always #5 clk = ~clk;

  // Timer model: EN rising edge loads the counter, then one decrement per clock;
  // reaching zero sets the sticky irq, cleared by writing 1 to STATUS.
  logic [31:0] tm_ctrl, tm_load, tm_cnt;
  logic        tm_irq;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tm_ctrl <= '0; tm_load <= '0; tm_cnt <= '0; tm_irq <= 1'b0;
    end else if (t_sel && t_we) begin
      case (t_addr)
        REG_CTRL: begin
          tm_ctrl <= t_wdata;
          if (t_wdata[CTRL_EN] && !tm_ctrl[CTRL_EN]) tm_cnt <= tm_load;
        end
        REG_LOAD:   tm_load <= t_wdata;
        REG_STATUS: if (t_wdata[0]) tm_irq <= 1'b0;
        default: ;
      endcase
    end else if (tm_ctrl[CTRL_EN] && tm_cnt != 0) begin
      tm_cnt <= tm_cnt - 1;
      if (tm_cnt == 1) tm_irq <= 1'b1;
    end
  end
  assign t_irq = tm_irq;

  // Monitor: stamps are the cycle number seen at the negedge following each posedge.
  typedef struct { logic [3:0] a; logic [31:0] d; } wr_t;
  wr_t  wrq[$];
  int   cyc = 0;
  int   busy_rise = 0, irq_rise = 0;
  logic busy_p = 1'b0, irq_p = 1'b0;
  always @(posedge clk) begin
    if (t_sel && t_we) wrq.push_back('{t_addr, t_wdata});
    if (busy && !busy_p) busy_rise = cyc;
    if (t_irq && !irq_p) irq_rise = cyc;
    busy_p = busy;
    irq_p  = t_irq;
    cyc++;
  end

  function automatic int rr_pick(input logic [3:0] m, input int last);
    for (int k = 1; k <= 4; k++)
      if (m[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic apply_reset;
    resetn = 1'b0; req = '0;
    repeat (2) tick;
    resetn = 1'b1;
    tick;
    wrq.delete();
  endtask

  task automatic wait_done(output logic [3:0] v, output int t, output bit ok);
    ok = 1'b0; v = '0; t = 0;
    for (int n = 0; n < 2000; n++) begin
      tick;
      if (done != 0) begin v = done; t = cyc; ok = 1'b1; return; end
    end
  endtask

  task automatic wait_busy(output int b);
    b = -1;
    for (int n = 0; n < 50; n++) begin
      tick;
      if (busy) begin b = cyc; return; end
    end
    checks++; errors++;
    $display("FAIL busy_timeout: got busy=0 expected busy=1 within 50 cycles");
  endtask

  task automatic test_reset;
    resetn = 1'b0; req = '0; dly = '0;
    tick;
    checks++;
    if ({busy, done, grant_id, t_sel, t_we, t_addr, t_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%0b done=%0h gid=%0d sel=%0b we=%0b addr=%0h wdata=%0h expected all 0",
               busy, done, grant_id, t_sel, t_we, t_addr, t_wdata);
    end
    resetn = 1'b1;
    repeat (3) tick;
    checks++;
    if (busy !== 1'b0 || t_sel !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%0b sel=%0b expected 0 0", busy, t_sel);
    end
  endtask

  task automatic test_single;
    logic [3:0] v; int t, b; bit ok;
    wrq.delete();
    dly[0] = 32'd5; req = 4'b0001;
    wait_busy(b);
    repeat (3) tick;
    dly[0] = 32'd99;
    wait_done(v, t, ok);
    checks++;
    if (!ok || v !== 4'b0001) begin
      errors++; $display("FAIL single_done: got ok=%0b done=%b expected 0001", ok, v);
    end
    checks++;
    if (t - irq_rise != 3) begin
      errors++; $display("FAIL single_irq_latency: got %0d expected 3", t - irq_rise);
    end
    checks++;
    if (t - b != 11) begin
      errors++; $display("FAIL single_total_latency: got %0d expected 11", t - b);
    end
    checks++;
    if (wrq.size() != 4 ||
        wrq[0].a !== REG_LOAD   || wrq[0].d !== 32'd5 ||
        wrq[1].a !== REG_CTRL   || wrq[1].d !== 32'h1 ||
        wrq[2].a !== REG_STATUS || wrq[2].d !== 32'h1 ||
        wrq[3].a !== REG_CTRL   || wrq[3].d !== 32'h0) begin
      errors++;
      $display("FAIL single_bus_seq: got %0d writes (first %0h=%0h) expected LOAD=5 CTRL=1 STATUS=1 CTRL=0",
               wrq.size(), (wrq.size() > 0) ? wrq[0].a : 4'h0, (wrq.size() > 0) ? wrq[0].d : 32'h0);
    end
    req = '0;
    tick;
    checks++;
    if (busy !== 1'b0 || done !== 4'b0 || t_irq !== 1'b0) begin
      errors++;
      $display("FAIL single_after: got busy=%0b done=%b irq=%0b expected 0 0000 0", busy, done, t_irq);
    end
  endtask

  task automatic test_fairness;
    logic [3:0] v, served; int t, m_last, exp; bit ok;
    apply_reset;
    dly = {32'd3, 32'd3, 32'd3, 32'd3};
    req = 4'b1111; m_last = 3; served = '0;
    for (int j = 0; j < 5; j++) begin
      exp = rr_pick(req, m_last);
      wait_done(v, t, ok);
      checks++;
      if (!ok || v !== 4'(1 << exp)) begin
        errors++; $display("FAIL fair_order_%0d: got done=%b expected client %0d", j, v, exp);
      end
      checks++;
      if (t - busy_rise != 9) begin
        errors++; $display("FAIL fair_latency_%0d: got %0d expected 9", j, t - busy_rise);
      end
      if (j < 4) served = served | v;
      m_last = exp;
    end
    checks++;
    if (served !== 4'b1111) begin
      errors++; $display("FAIL fair_coverage: got served=%b expected 1111", served);
    end
    req = '0;
    repeat (2) tick;
  endtask

  task automatic test_zero_delay;
    logic [3:0] v; int t, t0; bit ok;
    wrq.delete();
    dly[2] = 32'd0; req = 4'b0100; t0 = cyc;
    wait_done(v, t, ok);
    checks++;
    if (!ok || v !== 4'b0100 || t - t0 != 2) begin
      errors++; $display("FAIL zero_done: got done=%b after %0d cycles expected 0100 after 2", v, t - t0);
    end
    checks++;
    if (wrq.size() != 0) begin
      errors++; $display("FAIL zero_no_writes: got %0d writes expected 0", wrq.size());
    end
    req = '0;
    repeat (2) tick;
  endtask

  task automatic test_cancel;
    logic [3:0] v; int t, b; bit ok, saw;
    wrq.delete();
    dly[1] = 32'd1000; req = 4'b0010;
    wait_busy(b);
    while (cyc < b + 3 + 20) tick;
    req = '0; saw = 1'b0;
    repeat (6) begin tick; if (done != 0) saw = 1'b1; end
    checks++;
    if (saw || busy !== 1'b0) begin
      errors++; $display("FAIL cancel_no_done: got saw_done=%0b busy=%0b expected 0 0", saw, busy);
    end
    checks++;
    if (wrq.size() != 4 || wrq[0].d !== 32'd1000 ||
        wrq[2].a !== REG_STATUS || wrq[2].d !== 32'h1 ||
        wrq[3].a !== REG_CTRL   || wrq[3].d !== 32'h0) begin
      errors++; $display("FAIL cancel_bus_seq: got %0d writes expected LOAD=1000 CTRL=1 STATUS=1 CTRL=0", wrq.size());
    end
    dly[3] = 32'd4; req = 4'b1000;
    wait_done(v, t, ok);
    checks++;
    if (!ok || v !== 4'b1000 || t - busy_rise != 10) begin
      errors++; $display("FAIL cancel_followup: got done=%b latency %0d expected 1000 latency 10", v, t - busy_rise);
    end
    req = '0;
    repeat (2) tick;
  endtask

  task automatic test_race;
    logic [3:0] v; int t, b; bit ok;
    dly[2] = 32'd6; req = 4'b0100;
    wait_busy(b);
    while (cyc < b + 9) tick;
    checks++;
    if (t_irq !== 1'b1) begin
      errors++; $display("FAIL race_irq_edge: got irq=%0b expected 1", t_irq);
    end
    req = '0;
    wait_done(v, t, ok);
    checks++;
    if (!ok || v !== 4'b0100 || t - b != 12) begin
      errors++; $display("FAIL race_done: got done=%b latency %0d expected 0100 latency 12", v, t - b);
    end
    repeat (2) tick;
  endtask

  task automatic test_reset_mid;
    logic [3:0] v; int t, b; bit ok;
    dly[0] = 32'd50; req = 4'b0001;
    wait_busy(b);
    while (cyc < b + 15) tick;
    resetn = 1'b0;
    #1;
    checks++;
    if ({busy, done, grant_id, t_sel, t_we, t_addr, t_wdata} !== '0) begin
      errors++; $display("FAIL midreset_outputs: got busy=%0b sel=%0b addr=%0h expected all 0", busy, t_sel, t_addr);
    end
    req = '0;
    repeat (3) tick;
    dly[0] = 32'd2; dly[2] = 32'd4; req = 4'b0101;
    resetn = 1'b1;
    wait_done(v, t, ok);
    checks++;
    if (!ok || v !== 4'b0001 || t - busy_rise != 8) begin
      errors++; $display("FAIL midreset_first: got done=%b latency %0d expected 0001 latency 8", v, t - busy_rise);
    end
    req = 4'b0100;
    wait_done(v, t, ok);
    checks++;
    if (!ok || v !== 4'b0100 || t - busy_rise != 10) begin
      errors++; $display("FAIL midreset_second: got done=%b latency %0d expected 0100 latency 10", v, t - busy_rise);
    end
    req = '0;
    repeat (2) tick;
  endtask

  task automatic test_random;
    logic [3:0] v; int t, m_last, exp, d, lat; bit ok;
    apply_reset;
    m_last = 3;
    for (int i = 0; i < 4; i++) dly[i] = $urandom_range(0, 10);
    req = 4'($urandom_range(1, 15));
    for (int j = 0; j < 30; j++) begin
      exp = rr_pick(req, m_last);
      d   = int'(dly[exp]);
      lat = (d == 0) ? 1 : 6 + d;
      wait_done(v, t, ok);
      checks++;
      if (!ok || v !== 4'(1 << exp)) begin
        errors++; $display("FAIL rand_grant_%0d: got done=%b expected client %0d", j, v, exp);
      end
      checks++;
      if (t - busy_rise != lat) begin
        errors++; $display("FAIL rand_latency_%0d: got %0d expected %0d", j, t - busy_rise, lat);
      end
      checks++;
      if (wrq.size() != ((d == 0) ? 0 : 4) || (d != 0 && wrq[0].d !== 32'(d))) begin
        errors++; $display("FAIL rand_bus_%0d: got %0d writes expected %0d with LOAD=%0d",
                           j, wrq.size(), (d == 0) ? 0 : 4, d);
      end
      wrq.delete();
      m_last = exp;
      if ($urandom_range(0, 1) == 0) req[exp] = 1'b0;
      dly[exp] = $urandom_range(0, 10);
      for (int i = 0; i < 4; i++)
        if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          dly[i] = $urandom_range(0, 10);
        end
      if (req == 4'b0) begin
        req[$urandom_range(0, 3)] = 1'b1;
      end
    end
    req = '0;
    repeat (3) tick;
  endtask

  initial begin
    test_reset;
    test_single;
    test_fairness;
    test_zero_delay;
    test_cancel;
    test_race;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
